// File: rtl/cpu_io_pkg.sv
// Shared types and helpers for the buffered CPU I/O port.
//   hs_state_t : per-channel environment handshake states
//   rd_state_t : shared CPU read-sequencer states
//   chan_w()   : channel-index width, never narrower than one bit
package cpu_io_pkg;

    typedef enum logic {
        H_READY    = 1'b0,
        H_WAIT_LOW = 1'b1
    } hs_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_WAIT = 1'b1
    } rd_state_t;

    function automatic int chan_w(input int channels);
        return (channels <= 2) ? 1 : $clog2(channels);
    endfunction

endpackage

// File: rtl/io_fifo.sv
// Per-channel input FIFO.
//   i_clk, i_rst_n : clock, async active-low reset (empties the FIFO)
//   push, din      : write din when not full
//   pop            : drop the head word when not empty
//   full, empty    : occupancy flags
//   head           : oldest stored word (valid while !empty)
module io_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  full,
    output logic                  empty,
    output logic [DATA_WIDTH-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    // Extra MSB on each pointer tells a full ring from an empty one.
    logic [AW:0]           wr_ptr, rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)  wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop  && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge i_clk) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/cpu_io_port.sv
// Buffered CPU I/O port: CHANNELS input FIFOs fed by a four-phase
// status/control handshake, plus per-channel CPU-written output registers.
//   i_clk, i_rst_n          : clock, async active-low reset
//   i_rd_req, i_chan        : CPU read by channel; stalls via o_busy on empty FIFO
//   i_wr_req, i_wdata       : CPU write into o_out[i_chan], pulses o_out_stb
//   o_rdata, o_rd_valid     : read result and one-cycle completion pulse
//   o_busy                  : read pending on an empty channel
//   o_err                   : one-cycle pulse on access to channel >= CHANNELS
//   o_status, i_control     : per-channel ready / environment strobe
//   i_in, o_out             : packed per-channel data, channel c at [c*DATA_WIDTH +: DATA_WIDTH]
module cpu_io_port
    import cpu_io_pkg::*;
#(
    parameter  int DATA_WIDTH = 16,
    parameter  int CHANNELS   = 2,
    parameter  int DEPTH      = 4,
    localparam int CHAN_W     = chan_w(CHANNELS)
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_rd_req,
    input  logic                           i_wr_req,
    input  logic [CHAN_W-1:0]              i_chan,
    input  logic [DATA_WIDTH-1:0]          i_wdata,
    output logic [DATA_WIDTH-1:0]          o_rdata,
    output logic                           o_rd_valid,
    output logic                           o_busy,
    output logic                           o_err,
    output logic [CHANNELS-1:0]            o_status,
    input  logic [CHANNELS-1:0]            i_control,
    input  logic [CHANNELS*DATA_WIDTH-1:0] i_in,
    output logic [CHANNELS*DATA_WIDTH-1:0] o_out,
    output logic [CHANNELS-1:0]            o_out_stb
);
    logic [CHANNELS-1:0]                 push, pop, full, empty;
    logic [CHANNELS-1:0][DATA_WIDTH-1:0] head;

    rd_state_t         rs_q, rs_d;
    logic [CHAN_W-1:0] rchan_q, sel;
    logic              chan_ok, rd_bad, wr_bad, hit;

    assign chan_ok = int'(i_chan) < CHANNELS;
    assign rd_bad  = i_rd_req && (rs_q == R_IDLE) && !chan_ok;
    assign wr_bad  = i_wr_req && !chan_ok;
    assign o_busy  = (rs_q == R_WAIT);
    // While stalled the latched channel owns the read path.
    assign sel     = (rs_q == R_WAIT) ? rchan_q : i_chan;

    always_comb begin
        rs_d = rs_q;
        pop  = '0;
        hit  = 1'b0;
        case (rs_q)
            R_IDLE: if (i_rd_req && chan_ok) begin
                if (!empty[sel]) begin
                    hit      = 1'b1;
                    pop[sel] = 1'b1;
                end else begin
                    rs_d = R_WAIT;
                end
            end
            R_WAIT: if (!empty[sel]) begin
                hit      = 1'b1;
                pop[sel] = 1'b1;
                rs_d     = R_IDLE;
            end
            default: rs_d = R_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rs_q       <= R_IDLE;
            rchan_q    <= '0;
            o_rdata    <= '0;
            o_rd_valid <= 1'b0;
            o_err      <= 1'b0;
        end else begin
            rs_q <= rs_d;
            if (rs_q == R_IDLE && rs_d == R_WAIT) rchan_q <= i_chan;
            o_rd_valid <= hit || rd_bad;
            if (hit)         o_rdata <= head[sel];
            else if (rd_bad) o_rdata <= '0;
            // Bad read and bad write in one cycle still yield a single pulse.
            o_err <= rd_bad || wr_bad;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        hs_state_t             hs_q, hs_d;
        logic                  st_q, stb_q, wr_hit;
        logic [DATA_WIDTH-1:0] out_q;

        // Accept only on a registered ready so a long strobe captures once.
        assign push[c] = (hs_q == H_READY) && st_q && i_control[c];
        assign wr_hit  = i_wr_req && (int'(i_chan) == c);

        always_comb begin
            hs_d = hs_q;
            case (hs_q)
                H_READY:    if (push[c])       hs_d = H_WAIT_LOW;
                H_WAIT_LOW: if (!i_control[c]) hs_d = H_READY;
                default:                       hs_d = H_READY;
            endcase
        end

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                hs_q  <= H_READY;
                st_q  <= 1'b0;
                out_q <= '0;
                stb_q <= 1'b0;
            end else begin
                hs_q  <= hs_d;
                // A push leaves us in H_WAIT_LOW, so only a pop can change "full" here.
                st_q  <= (hs_d == H_READY) && !(full[c] && !pop[c]);
                stb_q <= wr_hit;
                if (wr_hit) out_q <= i_wdata;
            end
        end

        io_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo (
            .i_clk  (i_clk),
            .i_rst_n(i_rst_n),
            .push   (push[c]),
            .pop    (pop[c]),
            .din    (i_in[c*DATA_WIDTH +: DATA_WIDTH]),
            .full   (full[c]),
            .empty  (empty[c]),
            .head   (head[c])
        );

        assign o_status[c]                       = st_q;
        assign o_out_stb[c]                      = stb_q;
        assign o_out[c*DATA_WIDTH +: DATA_WIDTH] = out_q;
    end

endmodule

// File: tb/tb_cpu_io_port.sv
// Self-checking bench for cpu_io_port (3 channels, 16-bit, depth 4):
// directed scenarios with literal expectations, then randomized traffic,
// all compared every cycle against a queue-based behavioural model.
module tb_cpu_io_port;
    localparam int DW = 16;
    localparam int CH = 3;
    localparam int DP = 4;
    localparam int CW = 2;

    logic               clk = 1'b0, rst_n = 1'b0, rd_req = 1'b0, wr_req = 1'b0;
    logic [CW-1:0]      chan = '0;
    logic [DW-1:0]      wdata = '0;
    logic [DW-1:0]      rdata;
    logic               rd_valid, busy, err;
    logic [CH-1:0]      status, stb;
    logic [CH-1:0]      control = '0;
    logic [CH*DW-1:0]   in_bus = '0;
    logic [CH*DW-1:0]   out_bus;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cpu_io_port #(.DATA_WIDTH(DW), .CHANNELS(CH), .DEPTH(DP)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_rd_req  (rd_req),
        .i_wr_req  (wr_req),
        .i_chan    (chan),
        .i_wdata   (wdata),
        .o_rdata   (rdata),
        .o_rd_valid(rd_valid),
        .o_busy    (busy),
        .o_err     (err),
        .o_status  (status),
        .i_control (control),
        .i_in      (in_bus),
        .o_out     (out_bus),
        .o_out_stb (stb)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input int c, input logic [DW-1:0] v);
        in_bus[c*DW +: DW] = v;
    endtask

    // ---------------- behavioural model ----------------
    logic [DW-1:0]    q [CH][$];
    bit               cap [CH];      // a word was taken during the current strobe-high phase
    logic [CH-1:0]    m_status, m_stb, pu;
    logic             m_busy, m_valid, m_err;
    int               m_bch;
    logic [DW-1:0]    m_rdata;
    logic [CH*DW-1:0] m_out;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CH; c++) begin
                q[c].delete();
                cap[c] = 0;
            end
            m_status = '0; m_stb = '0; m_busy = 0; m_valid = 0; m_err = 0;
            m_bch = 0; m_rdata = '0; m_out = '0;
        end else begin
            pu = m_status & control;
            m_valid = 0; m_err = 0; m_stb = '0;
            // reads see the queues as they were before this edge's pushes
            if (!m_busy) begin
                if (rd_req) begin
                    if (int'(chan) >= CH) begin
                        m_valid = 1; m_err = 1; m_rdata = '0;
                    end else if (q[chan].size() != 0) begin
                        m_rdata = q[chan].pop_front(); m_valid = 1;
                    end else begin
                        m_busy = 1; m_bch = int'(chan);
                    end
                end
            end else if (q[m_bch].size() != 0) begin
                m_rdata = q[m_bch].pop_front(); m_valid = 1; m_busy = 0;
            end
            if (wr_req) begin
                if (int'(chan) >= CH) m_err = 1;
                else begin
                    m_out[int'(chan)*DW +: DW] = wdata;
                    m_stb[chan] = 1'b1;
                end
            end
            for (int c = 0; c < CH; c++) begin
                if (pu[c]) begin
                    q[c].push_back(in_bus[c*DW +: DW]);
                    cap[c] = 1;
                end else if (!control[c]) begin
                    cap[c] = 0;
                end
                m_status[c] = !cap[c] && (q[c].size() < DP);
            end
        end
    end

    always @(negedge clk) begin
        chk("valid",   64'(rd_valid), 64'(m_valid));
        if (m_valid) chk("rdata", 64'(rdata), 64'(m_rdata));
        chk("busy",    64'(busy),     64'(m_busy));
        chk("err",     64'(err),      64'(m_err));
        chk("status",  64'(status),   64'(m_status));
        chk("out_stb", 64'(stb),      64'(m_stb));
        chk("out",     64'(out_bus),  64'(m_out));
    end

    // ---------------- stimulus ----------------
    initial begin
        repeat (2) @(negedge clk);
        chk("rst_status", 64'(status),   64'h0);
        chk("rst_busy",   64'(busy),     64'h0);
        chk("rst_valid",  64'(rd_valid), 64'h0);
        chk("rst_out",    64'(out_bus),  64'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("release_status", 64'(status), 64'h7);

        // single capture on channel 0, then a read hit
        set_in(0, 16'd7); control[0] = 1'b1;
        @(negedge clk); chk("hs_captured", 64'(status[0]), 64'h0);
        @(negedge clk); control[0] = 1'b0;
        @(negedge clk); chk("hs_rearmed", 64'(status[0]), 64'h1);
        rd_req = 1'b1; chan = 2'd0;
        @(negedge clk);
        chk("hit_valid", 64'(rd_valid), 64'h1);
        chk("hit_data",  64'(rdata),    64'd7);
        rd_req = 1'b0;

        // read miss on channel 1, satisfied by a later push
        rd_req = 1'b1; chan = 2'd1;
        @(negedge clk); chk("miss_busy", 64'(busy), 64'h1);
        rd_req = 1'b0; set_in(1, 16'd8); control[1] = 1'b1;
        @(negedge clk); chk("miss_push_edge_valid", 64'(rd_valid), 64'h0);
        control[1] = 1'b0;
        @(negedge clk);
        chk("miss_valid",      64'(rd_valid), 64'h1);
        chk("miss_data",       64'(rdata),    64'd8);
        chk("miss_busy_clear", 64'(busy),     64'h0);

        // fill channel 1, then drain in order
        for (int i = 1; i <= 4; i++) begin
            set_in(1, 16'(i)); control[1] = 1'b1;
            @(negedge clk); control[1] = 1'b0;
            @(negedge clk);
        end
        chk("full_status", 64'(status[1]), 64'h0);
        rd_req = 1'b1; chan = 2'd1;
        @(negedge clk);
        chk("drain_first",      64'(rdata),     64'd1);
        chk("status_after_pop", 64'(status[1]), 64'h1);
        for (int i = 2; i <= 4; i++) begin
            @(negedge clk); chk("drain_order", 64'(rdata), 64'(i));
        end
        rd_req = 1'b0;

        // strobe held 5 cycles captures one word only
        set_in(0, 16'h55); control[0] = 1'b1;
        repeat (5) @(negedge clk);
        control[0] = 1'b0;
        @(negedge clk);
        rd_req = 1'b1; chan = 2'd0;
        @(negedge clk); chk("held_data", 64'(rdata), 64'h55);
        @(negedge clk); chk("held_single_push", 64'(busy), 64'h1);

        // write while stalled
        rd_req = 1'b0; wr_req = 1'b1; chan = 2'd1; wdata = 16'hABCD;
        @(negedge clk);
        chk("wr_out",  64'(out_bus[31:16]), 64'hABCD);
        chk("wr_stb",  64'(stb),            64'h2);
        chk("wr_busy", 64'(busy),           64'h1);
        wr_req = 1'b0;
        @(negedge clk);
        chk("wr_stb_once",  64'(stb),  64'h0);
        chk("wr_busy_hold", 64'(busy), 64'h1);

        // asynchronous reset during a stalled read
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy",   64'(busy),     64'h0);
        chk("arst_status", 64'(status),   64'h0);
        chk("arst_out",    64'(out_bus),  64'h0);
        chk("arst_stb",    64'(stb),      64'h0);
        chk("arst_valid",  64'(rd_valid), 64'h0);
        chk("arst_rdata",  64'(rdata),    64'h0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        chk("rerelease_status", 64'(status), 64'h7);
        chk("rerelease_busy",   64'(busy),   64'h0);

        // invalid channel: read and write together, one error pulse
        rd_req = 1'b1; wr_req = 1'b1; chan = 2'd3; wdata = 16'h1234;
        @(negedge clk);
        chk("bad_err",   64'(err),      64'h1);
        chk("bad_valid", 64'(rd_valid), 64'h1);
        chk("bad_rdata", 64'(rdata),    64'h0);
        chk("bad_nostb", 64'(stb),      64'h0);
        rd_req = 1'b0; wr_req = 1'b0;
        @(negedge clk); chk("bad_err_once", 64'(err), 64'h0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rd_req  = ($urandom_range(0, 3) == 0);
            wr_req  = ($urandom_range(0, 4) == 0);
            chan    = CW'($urandom_range(0, 3));
            wdata   = DW'($urandom);
            control = CH'($urandom);
            in_bus  = {DW'($urandom), DW'($urandom), DW'($urandom)};
            if (n == 1500) begin
                #2 rst_n = 1'b0;
                @(negedge clk); rst_n = 1'b1;
            end
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
